// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_gen_pipe_pkg                                                             |
// | Opcode constants and immediate-format encoding shared by imm_gen_pipe.       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+

`ifndef ENDIAN_SWP_32
`define ENDIAN_SWP_32(w) {w[7:0], w[15:8], w[23:16], w[31:24]}
`endif

package imm_gen_pipe_pkg;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;

    localparam logic [2:0] c_F3_SLL = 3'b001;
    localparam logic [2:0] c_F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_INV   = 3'd7
    } fmt_t;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_gen_pipe_if                                                              |
// | Instruction-in / immediate-out valid-ready bundle.                           |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+

interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_inv;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_inv
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_inv
    );
endinterface

`default_nettype wire

// File: rtl/imm_gen_pipe_imm_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode                                                                   |
// | Combinational RISC-V immediate extraction, sign-extended to XLEN.            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+

module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_t            o_fmt,
    output logic            o_inv
);

    localparam bit c_RV64 = (XLEN == 64);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_shift;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_sh5;
    logic [31:0] w_sh6;
    logic [31:0] w_imm32;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_is_shift = (w_funct3 == c_F3_SLL) || (w_funct3 == c_F3_SRX);

    // Every format fits in 32 bits; the final widening sign-extends to XLEN.
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_sh5   = {27'b0, i_instr[24:20]};
    assign w_sh6   = {26'b0, i_instr[25:20]};

    always_comb begin
        w_imm32 = '0;
        o_fmt   = FMT_INV;
        case (w_opcode)
            c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: begin
                o_fmt   = FMT_I;
                w_imm32 = w_imm_i;
            end
            c_OP_IMM: begin
                if (w_is_shift) begin
                    o_fmt   = FMT_SHAMT;
                    w_imm32 = c_RV64 ? w_sh6 : w_sh5;
                end else begin
                    o_fmt   = FMT_I;
                    w_imm32 = w_imm_i;
                end
            end
            c_OP_IMM32: begin
                if (c_RV64) begin
                    o_fmt   = w_is_shift ? FMT_SHAMT : FMT_I;
                    w_imm32 = w_is_shift ? w_sh5 : w_imm_i;
                end
            end
            c_OP_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = w_imm_s;
            end
            c_OP_BRANCH: begin
                o_fmt   = FMT_B;
                w_imm32 = w_imm_b;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = w_imm_u;
            end
            c_OP_JAL: begin
                o_fmt   = FMT_J;
                w_imm32 = w_imm_j;
            end
            c_OP_OP: begin
                o_fmt = FMT_R;
            end
            c_OP_OP32: begin
                if (c_RV64) begin
                    o_fmt = FMT_R;
                end
            end
            default: ;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));
    assign o_inv = (o_fmt == FMT_INV);

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_gen_pipe                                                                 |
// | One-cycle pipelined immediate generator with optional 2-entry skid buffer.   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+

module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    imm_gen_pipe_if.slave   bus
);

    logic [XLEN-1:0] w_dec_imm;
    fmt_t            w_dec_fmt;
    logic            w_dec_inv;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .i_instr (bus.in_instr),
        .o_imm   (w_dec_imm),
        .o_fmt   (w_dec_fmt),
        .o_inv   (w_dec_inv)
    );

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] c_ST_EMPTY = 2'd0;
            localparam logic [1:0] c_ST_ONE   = 2'd1;
            localparam logic [1:0] c_ST_FULL  = 2'd2;

            logic [1:0]      r_state;
            logic [1:0]      w_state_nxt;
            logic            r_in_ready;
            logic            w_push;
            logic            w_pop;
            logic            w_out_valid;
            logic            w_load_head;
            logic            w_load_skid;
            logic            w_head_from_skid;
            logic [XLEN-1:0] r_head_imm;
            fmt_t            r_head_fmt;
            logic            r_head_inv;
            logic [XLEN-1:0] r_skid_imm;
            fmt_t            r_skid_fmt;
            logic            r_skid_inv;

            assign w_push = bus.in_valid && r_in_ready;
            assign w_pop  = (r_state != c_ST_EMPTY) && bus.out_ready;

            // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= c_ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != c_ST_FULL);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_ST_EMPTY: if (w_push) w_state_nxt = c_ST_ONE;
                    c_ST_ONE: begin
                        if (w_push && !w_pop)      w_state_nxt = c_ST_FULL;
                        else if (!w_push && w_pop) w_state_nxt = c_ST_EMPTY;
                    end
                    c_ST_FULL:  if (w_pop) w_state_nxt = c_ST_ONE;
                    default:    w_state_nxt = c_ST_EMPTY;
                endcase
            end

            always_comb begin
                w_out_valid      = (r_state != c_ST_EMPTY);
                w_load_head      = 1'b0;
                w_load_skid      = 1'b0;
                w_head_from_skid = 1'b0;
                case (r_state)
                    c_ST_EMPTY: w_load_head = w_push;
                    c_ST_ONE: begin
                        w_load_head = w_push && w_pop;
                        w_load_skid = w_push && !w_pop;
                    end
                    c_ST_FULL:  w_head_from_skid = w_pop;
                    default: ;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_head_imm <= '0;
                    r_head_fmt <= FMT_R;
                    r_head_inv <= 1'b0;
                    r_skid_imm <= '0;
                    r_skid_fmt <= FMT_R;
                    r_skid_inv <= 1'b0;
                end else begin
                    if (w_load_head) begin
                        r_head_imm <= w_dec_imm;
                        r_head_fmt <= w_dec_fmt;
                        r_head_inv <= w_dec_inv;
                    end else if (w_head_from_skid) begin
                        r_head_imm <= r_skid_imm;
                        r_head_fmt <= r_skid_fmt;
                        r_head_inv <= r_skid_inv;
                    end
                    if (w_load_skid) begin
                        r_skid_imm <= w_dec_imm;
                        r_skid_fmt <= w_dec_fmt;
                        r_skid_inv <= w_dec_inv;
                    end
                end
            end

            assign bus.in_ready  = r_in_ready;
            assign bus.out_valid = w_out_valid;
            assign bus.out_imm   = r_head_imm;
            assign bus.out_fmt   = r_head_fmt;
            assign bus.out_inv   = r_head_inv;
        end else begin : g_single
            logic            r_valid;
            logic            w_in_ready;
            logic            w_push;
            logic [XLEN-1:0] r_imm;
            fmt_t            r_fmt;
            logic            r_inv;

            assign w_in_ready = !r_valid || bus.out_ready;
            assign w_push     = bus.in_valid && w_in_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_imm   <= '0;
                    r_fmt   <= FMT_R;
                    r_inv   <= 1'b0;
                end else if (w_push) begin
                    r_valid <= 1'b1;
                    r_imm   <= w_dec_imm;
                    r_fmt   <= w_dec_fmt;
                    r_inv   <= w_dec_inv;
                end else if (bus.out_ready) begin
                    r_valid <= 1'b0;
                end
            end

            assign bus.in_ready  = w_in_ready;
            assign bus.out_valid = r_valid;
            assign bus.out_imm   = r_imm;
            assign bus.out_fmt   = r_fmt;
            assign bus.out_inv   = r_inv;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised successor to the combinational ImmGen in the fetch/decode stage. It accepts raw 32-bit RISC-V instruction words over a valid/ready handshake. It produces a sign-extended XLEN-wide immediate, an immediate-format code and an invalid-opcode flag, with one cycle of latency. A 2-entry skid buffer gives full throughput under decode-stage backpressure.

## Interface
Parameters:
- XLEN, 32: immediate output width; legal values are 32 and 64.
- SKID, 1: 1 = 2-entry skid buffer (full throughput); 0 = single register (in_ready = !out_valid || out_ready).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_instr  input  32  instruction word, little-endian (already byte-swapped upstream).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  immediate format: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, INV=7.
- out_inv  output  1  opcode not recognised.

## Operation
- Decode uses opcode in_instr[6:0]:
  - I-format: 0000011, 0010011, 1100111, 1110011; also 0011011 when XLEN=64.
    - imm = sext(instr[31:20]).
    - Exception: SHAMT for 0010011/0011011 with funct3 001/101. imm = zext(instr[24:20]) for XLEN=32 and for 0011011; zext(instr[25:20]) for 0010011 when XLEN=64.
  - S-format: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B-format: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-format: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}).
  - J-format: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-format: 0110011, 0111011 (0111011 only when XLEN=64). imm = 0, fmt = R.
  - Any other opcode: imm = 0, fmt = INV, out_inv = 1. The word is still passed through and never dropped.
- Sign-extension is always from the top immediate bit to XLEN.
- A transfer occurs on a cycle where valid && ready on either side.
- Output ordering is strictly FIFO.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync-released internally via rst_n sampled at clk):
  - out_valid = 0, out_imm = 0, out_fmt = 0, out_inv = 0.
  - Skid occupancy = 0; in_ready = 1 in the first cycle after release.
- Latency: a word accepted in cycle N appears with out_valid = 1 in cycle N+1.
- Throughput: one word per cycle while out_ready = 1.
- Skid (SKID=1), occupancy 0/1/2:
  - in_ready = (occupancy < 2), registered, so it has no combinational path from out_ready.
  - Full (2) with out_ready = 1: pop. in_ready becomes 1 next cycle, and no accept occurs this cycle.
  - Occupancy 1 with push and pop in the same cycle: occupancy stays 1 and the output advances to the new word.
  - Empty: out_valid = 0, and out_imm holds its last value (not required to be zero).
- Reset mid-operation: all buffered words are discarded immediately (async), and out_valid drops the same instant.

## Structure
- Shared package:
  - opcode constants.
  - fmt_t enum (R..INV, 3 bits).
  - the ENDIAN_SWP_32 macro already in types.vh.
- Sub-module imm_decode: purely combinational, instr -> {imm, fmt, inv}, parametrised on XLEN. It is reused by the skid stage and is testable standalone against the existing immgen gold vectors.
- The top level holds only the handshake, skid registers and occupancy counter.

## Test plan
- XLEN=32, out_ready=1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=I, inv=0.
- Back-to-back push of 0x123450B7 (lui), 0xFFDFF06F (jal -4) and 0xFE000CE3 (beq -8) -> three consecutive outputs: 0x12345000/U, 0xFFFFFFFC/J, 0xFFFFFFF8/B; no bubbles.
- out_ready=0, push 3 words -> first two accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready -> outputs appear in order and the third word is accepted once occupancy < 2.
- Push 0x0000007F (unknown opcode) -> out_imm=0, fmt=INV(7), inv=1. Also push 0x01F0D093 (srli x1,x1,31) -> imm=0x1F, fmt=SHAMT.
- XLEN=64: push 0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF. Push 0x03F0D093 (srli shamt 63) -> imm=0x3F, fmt=SHAMT.
- Assert rst_n low with 2 words buffered -> out_valid=0 immediately. After release, in_ready=1 and no stale word is emitted.
- Run the existing 27-vector immgen gold file through the block -> 0 mismatches.
